// File: rtl/garage_pkg.sv
// garage_pkg: shared types, constants and helpers for the garage gate controller
package garage_pkg;

    localparam int NUM_SLOTS = 6;
    localparam int SLOT_W    = 3;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY_OPEN,
        EXIT_OPEN
    } state_t;

    // seven-segment patterns, bit 0 = a ... bit 6 = g, active-high
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;

    function automatic logic [SLOT_W-1:0] free_count(input logic [NUM_SLOTS-1:0] o);
        int n;
        n = 0;
        for (int i = 0; i < NUM_SLOTS; i++) n += int'(o[i]);
        return SLOT_W'(NUM_SLOTS - n);
    endfunction

    function automatic logic [6:0] seg_decode(input logic [SLOT_W-1:0] n);
        case (n)
            3'd0:    return SEG_0;
            3'd1:    return SEG_1;
            3'd2:    return SEG_2;
            3'd3:    return SEG_3;
            3'd4:    return SEG_4;
            3'd5:    return SEG_5;
            3'd6:    return SEG_6;
            default: return 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/garage_free_slot_enc.sv
// garage_free_slot_enc: lowest-index free slot priority encoder over the occupancy vector
module garage_free_slot_enc
    import garage_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] occ,
    output logic [SLOT_W-1:0]    idx,
    output logic                 any_free
);

    // scan downward so the lowest free index is the last one written
    always_comb begin
        idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (!occ[i]) idx = SLOT_W'(i);
    end

    assign any_free = ~&occ;

endmodule

// File: rtl/garage_gate_ctrl.sv
// garage_gate_ctrl: slot occupancy, entry/exit arbitration and gate timing
// Optional free-count seven-segment output enabled by defining GARAGE_SEG_EN.
module garage_gate_ctrl
    import garage_pkg::*;
#(
    parameter int GATE_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 entry_req,
    input  logic                 exit_req,
    input  logic [SLOT_W-1:0]    exit_slot,
    output logic [NUM_SLOTS-1:0] occ,
    output logic [SLOT_W-1:0]    free_cnt,
    output logic                 full,
    output logic                 empty,
    output logic                 entry_gate,
    output logic                 exit_gate,
    output logic                 assign_valid,
    output logic [SLOT_W-1:0]    assign_slot,
    output logic                 reject,
    output logic                 err
`ifdef GARAGE_SEG_EN
    ,
    output logic [6:0]           seg
`endif
);

    localparam logic [7:0] TIMER_LOAD = 8'(GATE_CYCLES - 1);

    state_t                 state, state_n;
    logic [7:0]             timer, timer_n;
    logic                   entry_d, exit_d;
    logic                   entry_pend, exit_pend;
    logic                   entry_clr, exit_clr;
    logic [SLOT_W-1:0]      exit_slot_q;
    logic [NUM_SLOTS-1:0]   occ_n;
    logic                   entry_gate_n, exit_gate_n;
    logic                   assign_valid_n, reject_n, err_n;
    logic [SLOT_W-1:0]      assign_slot_n;
    logic [SLOT_W-1:0]      free_idx;
    logic                   any_free;
    logic [7:0]             occ_ext;
    logic                   exit_ok;
    logic                   entry_rise, exit_rise;

    garage_free_slot_enc u_enc (
        .occ      (occ),
        .idx      (free_idx),
        .any_free (any_free)
    );

    assign entry_rise = entry_req & ~entry_d;
    assign exit_rise  = exit_req & ~exit_d;
    assign occ_ext    = {2'b00, occ};
    assign exit_ok    = (exit_slot_q < SLOT_W'(NUM_SLOTS)) && occ_ext[exit_slot_q];

    // edge detection and pending requests; a service clear beats a rise on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_d     <= 1'b0;
            exit_d      <= 1'b0;
            entry_pend  <= 1'b0;
            exit_pend   <= 1'b0;
            exit_slot_q <= '0;
        end else begin
            entry_d    <= entry_req;
            exit_d     <= exit_req;
            entry_pend <= ~entry_clr & (entry_pend | entry_rise);
            exit_pend  <= ~exit_clr & (exit_pend | exit_rise);
            if (exit_rise && !exit_pend) exit_slot_q <= exit_slot;
        end
    end

    // next state and output decisions; exit requests win over entry in IDLE
    always_comb begin
        state_n        = state;
        timer_n        = timer;
        occ_n          = occ;
        entry_gate_n   = entry_gate;
        exit_gate_n    = exit_gate;
        assign_valid_n = 1'b0;
        assign_slot_n  = assign_slot;
        reject_n       = 1'b0;
        err_n          = 1'b0;
        entry_clr      = 1'b0;
        exit_clr       = 1'b0;
        case (state)
            IDLE: begin
                if (exit_pend) begin
                    exit_clr = 1'b1;
                    if (exit_ok) begin
                        occ_n       = occ & ~(NUM_SLOTS'(1) << exit_slot_q);
                        exit_gate_n = 1'b1;
                        timer_n     = TIMER_LOAD;
                        state_n     = EXIT_OPEN;
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (entry_pend) begin
                    entry_clr = 1'b1;
                    if (any_free) begin
                        occ_n          = occ | (NUM_SLOTS'(1) << free_idx);
                        assign_slot_n  = free_idx;
                        assign_valid_n = 1'b1;
                        entry_gate_n   = 1'b1;
                        timer_n        = TIMER_LOAD;
                        state_n        = ENTRY_OPEN;
                    end else begin
                        reject_n = 1'b1;
                    end
                end
            end
            ENTRY_OPEN, EXIT_OPEN: begin
                if (timer == 8'd0) begin
                    entry_gate_n = 1'b0;
                    exit_gate_n  = 1'b0;
                    state_n      = IDLE;
                end else begin
                    timer_n = timer - 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state register with occupancy and all derived outputs registered together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= 8'd0;
            occ          <= '0;
            free_cnt     <= SLOT_W'(NUM_SLOTS);
            full         <= 1'b0;
            empty        <= 1'b1;
            entry_gate   <= 1'b0;
            exit_gate    <= 1'b0;
            assign_valid <= 1'b0;
            assign_slot  <= '0;
            reject       <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            occ          <= occ_n;
            free_cnt     <= free_count(occ_n);
            full         <= &occ_n;
            empty        <= ~|occ_n;
            entry_gate   <= entry_gate_n;
            exit_gate    <= exit_gate_n;
            assign_valid <= assign_valid_n;
            assign_slot  <= assign_slot_n;
            reject       <= reject_n;
            err          <= err_n;
        end
    end

`ifdef GARAGE_SEG_EN
    // display digit follows the free count on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seg <= SEG_6;
        else        seg <= seg_decode(free_count(occ_n));
    end
`endif

endmodule

// File: tb/tb_garage_gate_ctrl.sv
// tb_garage_gate_ctrl: table-driven scoreboard bench for garage_gate_ctrl
module tb_garage_gate_ctrl;

    localparam int G = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [2:0] exit_slot = 3'd0;
    logic [5:0] occ;
    logic [2:0] free_cnt;
    logic       full, empty, entry_gate, exit_gate, assign_valid, reject, err;
    logic [2:0] assign_slot;
`ifdef GARAGE_SEG_EN
    logic [6:0] seg;
`endif

    int checks = 0;
    int failures = 0;

    garage_gate_ctrl #(.GATE_CYCLES(G)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .entry_req    (entry_req),
        .exit_req     (exit_req),
        .exit_slot    (exit_slot),
        .occ          (occ),
        .free_cnt     (free_cnt),
        .full         (full),
        .empty        (empty),
        .entry_gate   (entry_gate),
        .exit_gate    (exit_gate),
        .assign_valid (assign_valid),
        .assign_slot  (assign_slot),
        .reject       (reject),
        .err          (err)
`ifdef GARAGE_SEG_EN
        ,
        .seg          (seg)
`endif
    );

    always #5 clk = ~clk;

    // kind: 1 admitted, 2 rejected, 3 exit error, 4 exit served
    typedef struct {
        bit         is_exit;
        logic [2:0] slot;
        int         kind;
        logic [2:0] exp_slot;
        logic [5:0] exp_occ;
    } op_t;

    op_t tbl[22];
    op_t sb[$];

    function automatic op_t mk(bit is_exit, logic [2:0] slot, int kind, logic [2:0] exp_slot, logic [5:0] exp_occ);
        op_t o;
        o.is_exit = is_exit;
        o.slot = slot;
        o.kind = kind;
        o.exp_slot = exp_slot;
        o.exp_occ = exp_occ;
        return o;
    endfunction

    function automatic logic [6:0] seg_ref(int n);
        logic [6:0] t [7] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};
        return t[n];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_occ(logic [5:0] e);
        chk("occ", 32'(occ), 32'(e));
        chk("free_cnt", 32'(free_cnt), 32'(6 - $countones(e)));
        chk("full", 32'(full), 32'(e == 6'h3F));
        chk("empty", 32'(empty), 32'(e == 6'h00));
`ifdef GARAGE_SEG_EN
        chk("seg", 32'(seg), 32'(seg_ref(6 - $countones(e))));
`endif
    endtask

    task automatic gate_width(bit is_exit, output int n);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((is_exit ? exit_gate : entry_gate) !== 1'b1) break;
            n++;
        end
    endtask

    task automatic run_op(op_t op);
        int lat, kind, w;
        op_t e;
        sb.push_back(op);
        @(negedge clk);
        if (op.is_exit) begin
            exit_slot = op.slot;
            exit_req = 1'b1;
        end else begin
            entry_req = 1'b1;
        end
        lat = 0;
        kind = 0;
        while (kind == 0 && lat < 10) begin
            @(negedge clk);
            lat++;
            kind = assign_valid ? 1 : reject ? 2 : err ? 3 : exit_gate ? 4 : 0;
        end
        e = sb.pop_front();
        if (kind == 0) begin
            checks++;
            failures++;
            $display("FAIL timeout: no response to op kind %0d", e.kind);
        end else begin
            chk("latency", 32'(lat), 32'd2);
            chk("kind", 32'(kind), 32'(e.kind));
            chk_occ(e.exp_occ);
            if (kind == 1) chk("assign_slot", 32'(assign_slot), 32'(e.exp_slot));
            chk("entry_gate", 32'(entry_gate), 32'(kind == 1));
            chk("exit_gate", 32'(exit_gate), 32'(kind == 4));
            if (kind == 1 || kind == 4) begin
                gate_width(kind == 4, w);
                chk("gate_width", 32'(w), 32'(G));
            end else begin
                @(negedge clk);
                chk("pulse_one_cycle", 32'({reject, err}), 32'd0);
            end
        end
        entry_req = 1'b0;
        exit_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int w;
        for (int i = 0; i < 6; i++) tbl[i] = mk(0, 0, 1, 3'(i), 6'((1 << (i + 1)) - 1));
        tbl[6]  = mk(0, 0, 2, 0, 6'b111111);
        tbl[7]  = mk(1, 7, 3, 0, 6'b111111);
        tbl[8]  = mk(1, 5, 4, 0, 6'b011111);
        tbl[9]  = mk(1, 4, 4, 0, 6'b001111);
        tbl[10] = mk(1, 3, 4, 0, 6'b000111);
        tbl[11] = mk(1, 1, 4, 0, 6'b000101);
        tbl[12] = mk(0, 0, 1, 1, 6'b000111);
        tbl[13] = mk(1, 2, 4, 0, 6'b000011);
        tbl[14] = mk(1, 1, 4, 0, 6'b000001);
        tbl[15] = mk(1, 4, 3, 0, 6'b000001);
        tbl[16] = mk(1, 7, 3, 0, 6'b000001);
        tbl[17] = mk(0, 0, 1, 1, 6'b000011);
        tbl[18] = mk(0, 0, 1, 2, 6'b000111);
        tbl[19] = mk(0, 0, 1, 3, 6'b001111);
        tbl[20] = mk(0, 0, 1, 4, 6'b011111);
        tbl[21] = mk(0, 0, 1, 5, 6'b111111);

        repeat (3) @(negedge clk);
        chk_occ(6'b000000);
        chk("reset_gates", 32'({entry_gate, exit_gate}), 32'd0);
        chk("reset_pulses", 32'({assign_valid, reject, err}), 32'd0);
        chk("reset_assign_slot", 32'(assign_slot), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (tbl[k]) run_op(tbl[k]);

        // simultaneous entry and exit on a full garage: exit first, entry reuses the freed slot
        exit_slot = 3'd2;
        entry_req = 1'b1;
        exit_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("sim_exit_gate", 32'(exit_gate), 32'd1);
        chk("sim_entry_held", 32'(entry_gate), 32'd0);
        chk_occ(6'b111011);
        gate_width(1'b1, w);
        chk("sim_exit_width", 32'(w), 32'(G));
        chk("sim_closed_gap", 32'({entry_gate, exit_gate}), 32'd0);
        @(negedge clk);
        chk("sim_entry_gate", 32'(entry_gate), 32'd1);
        chk("sim_assign_valid", 32'(assign_valid), 32'd1);
        chk("sim_assign_slot", 32'(assign_slot), 32'd2);
        chk_occ(6'b111111);

        // reset during the third open cycle of the entry gate
        repeat (2) @(negedge clk);
        chk("pre_reset_gate", 32'(entry_gate), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gate", 32'({entry_gate, exit_gate}), 32'd0);
        chk_occ(6'b000000);
        entry_req = 1'b0;
        exit_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_op(mk(0, 0, 1, 0, 6'b000001));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
